// File: rtl/rs_scheduler.sv
// Reservation-station scheduler: holds dispatched ops until both operands are
// ready, wakes operands from the ALU/load result buses, and issues the
// lowest-index ready entry to the ALU once per cycle.
module rs_scheduler #(
  parameter int unsigned RS_SIZE = 8,
  parameter int unsigned OPT_W   = 6,
  parameter int unsigned ROB_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             rb,
  output logic             rs_full,
  input  logic             rs_ena,
  input  logic [OPT_W-1:0] rs_opt,
  input  logic [ROB_W-1:0] rs_src1,
  input  logic [ROB_W-1:0] rs_src2,
  input  logic [31:0]      rs_val1,
  input  logic [31:0]      rs_val2,
  input  logic [31:0]      rs_imm,
  input  logic [ROB_W-1:0] rs_rob_idx,
  input  logic             cdb_alu_valid,
  input  logic [ROB_W-1:0] cdb_alu_src,
  input  logic [31:0]      cdb_alu_val,
  input  logic             cdb_ld_valid,
  input  logic [ROB_W-1:0] cdb_ld_src,
  input  logic [31:0]      cdb_ld_val,
  output logic             alu_ena,
  output logic [OPT_W-1:0] alu_opt,
  output logic [31:0]      alu_val1,
  output logic [31:0]      alu_val2,
  output logic [31:0]      alu_imm,
  output logic [ROB_W-1:0] alu_rob_idx
);

  localparam int unsigned IDX_W = $clog2(RS_SIZE);
  localparam int unsigned CNT_W = IDX_W + 1;

  logic [RS_SIZE-1:0] valid_q, valid_d;
  logic [OPT_W-1:0]   opt_q  [RS_SIZE];
  logic [OPT_W-1:0]   opt_d  [RS_SIZE];
  logic [ROB_W-1:0]   src1_q [RS_SIZE];
  logic [ROB_W-1:0]   src1_d [RS_SIZE];
  logic [ROB_W-1:0]   src2_q [RS_SIZE];
  logic [ROB_W-1:0]   src2_d [RS_SIZE];
  logic [31:0]        val1_q [RS_SIZE];
  logic [31:0]        val1_d [RS_SIZE];
  logic [31:0]        val2_q [RS_SIZE];
  logic [31:0]        val2_d [RS_SIZE];
  logic [31:0]        imm_q  [RS_SIZE];
  logic [31:0]        imm_d  [RS_SIZE];
  logic [ROB_W-1:0]   rob_q  [RS_SIZE];
  logic [ROB_W-1:0]   rob_d  [RS_SIZE];

  logic             issue_any, free_any;
  logic [IDX_W-1:0] issue_idx, free_idx;
  logic [CNT_W-1:0] count;

  // Operand capture from the result buses; ALU bus wins on identical tags.
  function automatic logic [ROB_W+31:0] wake(
    input logic [ROB_W-1:0] src,
    input logic [31:0]      val,
    input logic             a_v,
    input logic [ROB_W-1:0] a_src,
    input logic [31:0]      a_val,
    input logic             l_v,
    input logic [ROB_W-1:0] l_src,
    input logic [31:0]      l_val
  );
    logic [ROB_W+31:0] r;
    r = {src, val};
    if (src != '0) begin
      if (a_v && src == a_src) r = {{ROB_W{1'b0}}, a_val};
      else if (l_v && src == l_src) r = {{ROB_W{1'b0}}, l_val};
    end
    return r;
  endfunction

  // Lowest-index issuable entry, lowest-index free entry, occupancy count.
  always_comb begin
    issue_any = 1'b0;
    issue_idx = '0;
    free_any  = 1'b0;
    free_idx  = '0;
    count     = '0;
    for (int i = int'(RS_SIZE) - 1; i >= 0; i--) begin
      if (valid_q[i] && src1_q[i] == '0 && src2_q[i] == '0) begin
        issue_any = 1'b1;
        issue_idx = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
      count = count + CNT_W'(valid_q[i]);
    end
  end

  // Includes the incoming write so the dispatcher sees the slot it is about to use.
  assign rs_full = (count + CNT_W'(rs_ena)) >= CNT_W'(RS_SIZE - 1);

  // Next entry state: rollback flush, or issue + wakeup + insert.
  always_comb begin
    valid_d = valid_q;
    opt_d   = opt_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    val1_d  = val1_q;
    val2_d  = val2_q;
    imm_d   = imm_q;
    rob_d   = rob_q;
    if (rb) begin
      valid_d = '0;
    end else begin
      if (issue_any) valid_d[issue_idx] = 1'b0;
      for (int i = 0; i < int'(RS_SIZE); i++) begin
        if (valid_q[i]) begin
          {src1_d[i], val1_d[i]} = wake(src1_q[i], val1_q[i], cdb_alu_valid, cdb_alu_src,
                                        cdb_alu_val, cdb_ld_valid, cdb_ld_src, cdb_ld_val);
          {src2_d[i], val2_d[i]} = wake(src2_q[i], val2_q[i], cdb_alu_valid, cdb_alu_src,
                                        cdb_alu_val, cdb_ld_valid, cdb_ld_src, cdb_ld_val);
        end
      end
      // Free slot is chosen from start-of-cycle state, so an issuing slot is never reused.
      if (rs_ena && free_any) begin
        valid_d[free_idx] = 1'b1;
        opt_d[free_idx]   = rs_opt;
        imm_d[free_idx]   = rs_imm;
        rob_d[free_idx]   = rs_rob_idx;
        {src1_d[free_idx], val1_d[free_idx]} = wake(rs_src1, rs_val1, cdb_alu_valid,
            cdb_alu_src, cdb_alu_val, cdb_ld_valid, cdb_ld_src, cdb_ld_val);
        {src2_d[free_idx], val2_d[free_idx]} = wake(rs_src2, rs_val2, cdb_alu_valid,
            cdb_alu_src, cdb_alu_val, cdb_ld_valid, cdb_ld_src, cdb_ld_val);
      end
    end
  end

  // Valid bits and registered issue port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= '0;
      alu_ena     <= 1'b0;
      alu_opt     <= '0;
      alu_val1    <= '0;
      alu_val2    <= '0;
      alu_imm     <= '0;
      alu_rob_idx <= '0;
    end else if (!rdy) begin
      alu_ena <= 1'b0;
    end else begin
      valid_q <= valid_d;
      alu_ena <= issue_any && !rb;
      if (issue_any && !rb) begin
        alu_opt     <= opt_q[issue_idx];
        alu_val1    <= val1_q[issue_idx];
        alu_val2    <= val2_q[issue_idx];
        alu_imm     <= imm_q[issue_idx];
        alu_rob_idx <= rob_q[issue_idx];
      end
    end
  end

  // Entry payload; contents of invalid entries are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (rdy) begin
      opt_q  <= opt_d;
      src1_q <= src1_d;
      src2_q <= src2_d;
      val1_q <= val1_d;
      val2_q <= val2_d;
      imm_q  <= imm_d;
      rob_q  <= rob_d;
    end
  end

endmodule

// File: tb/tb_rs_scheduler.sv
// Bench for rs_scheduler: directed vector table, hand sequences for full,
// rollback, stall and reset, then random traffic against a slot-array model.
module tb_rs_scheduler;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy, rb, rs_full, rs_ena;
  logic [5:0]  rs_opt;
  logic [4:0]  rs_src1, rs_src2, rs_rob_idx;
  logic [31:0] rs_val1, rs_val2, rs_imm;
  logic        cdb_alu_valid, cdb_ld_valid;
  logic [4:0]  cdb_alu_src, cdb_ld_src;
  logic [31:0] cdb_alu_val, cdb_ld_val;
  logic        alu_ena;
  logic [5:0]  alu_opt;
  logic [31:0] alu_val1, alu_val2, alu_imm;
  logic [4:0]  alu_rob_idx;

  rs_scheduler dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rb(rb), .rs_full(rs_full),
    .rs_ena(rs_ena), .rs_opt(rs_opt), .rs_src1(rs_src1), .rs_src2(rs_src2),
    .rs_val1(rs_val1), .rs_val2(rs_val2), .rs_imm(rs_imm), .rs_rob_idx(rs_rob_idx),
    .cdb_alu_valid(cdb_alu_valid), .cdb_alu_src(cdb_alu_src), .cdb_alu_val(cdb_alu_val),
    .cdb_ld_valid(cdb_ld_valid), .cdb_ld_src(cdb_ld_src), .cdb_ld_val(cdb_ld_val),
    .alu_ena(alu_ena), .alu_opt(alu_opt), .alu_val1(alu_val1), .alu_val2(alu_val2),
    .alu_imm(alu_imm), .alu_rob_idx(alu_rob_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rdy, rb, ena;
    logic [5:0] opt;
    logic [4:0] s1, s2, rob;
    logic [31:0] v1, v2, imm;
    logic av; logic [4:0] asrc; logic [31:0] aval;
    logic lv; logic [4:0] lsrc; logic [31:0] lval;
  } in_t;

  typedef struct {
    in_t in;
    logic e_full, e_ena;
    logic [31:0] e_v1;
    logic [4:0] e_rob;
  } vec_t;

  int total = 0;
  int bad = 0;

  // Model: a plain array of slots plus the last issued packet.
  logic        m_valid [N];
  logic [5:0]  m_opt [N];
  logic [4:0]  m_s1 [N], m_s2 [N], m_rob [N];
  logic [31:0] m_v1 [N], m_v2 [N], m_imm [N];
  logic        m_ena;
  logic [5:0]  m_opt_o;
  logic [31:0] m_v1_o, m_v2_o, m_imm_o;
  logic [4:0]  m_rob_o;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t idle_in();
    in_t r;
    r = '{default: '0};
    r.rdy = 1'b1;
    return r;
  endfunction

  function automatic logic [36:0] mwake(logic [4:0] s, logic [31:0] v, in_t x);
    if (s != 0 && x.av && s == x.asrc) return {5'd0, x.aval};
    if (s != 0 && x.lv && s == x.lsrc) return {5'd0, x.lval};
    return {s, v};
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) if (m_valid[i]) c++;
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    m_ena = 0; m_opt_o = 0; m_v1_o = 0; m_v2_o = 0; m_imm_o = 0; m_rob_o = 0;
  endtask

  task automatic model_step(input in_t x);
    int iss, fr;
    if (!x.rdy) begin m_ena = 0; return; end
    if (x.rb) begin
      for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
      m_ena = 0;
      return;
    end
    iss = -1; fr = -1;
    for (int i = 0; i < N; i++) begin
      if (iss < 0 && m_valid[i] && m_s1[i] == 0 && m_s2[i] == 0) iss = i;
      if (fr < 0 && !m_valid[i]) fr = i;
    end
    m_ena = (iss >= 0);
    if (iss >= 0) begin
      m_opt_o = m_opt[iss]; m_v1_o = m_v1[iss]; m_v2_o = m_v2[iss];
      m_imm_o = m_imm[iss]; m_rob_o = m_rob[iss];
      m_valid[iss] = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (m_valid[i]) begin
        {m_s1[i], m_v1[i]} = mwake(m_s1[i], m_v1[i], x);
        {m_s2[i], m_v2[i]} = mwake(m_s2[i], m_v2[i], x);
      end
    end
    if (x.ena && fr >= 0) begin
      m_valid[fr] = 1'b1; m_opt[fr] = x.opt; m_imm[fr] = x.imm; m_rob[fr] = x.rob;
      {m_s1[fr], m_v1[fr]} = mwake(x.s1, x.v1, x);
      {m_s2[fr], m_v2[fr]} = mwake(x.s2, x.v2, x);
    end
  endtask

  task automatic drive(input in_t x);
    rdy = x.rdy; rb = x.rb; rs_ena = x.ena; rs_opt = x.opt;
    rs_src1 = x.s1; rs_src2 = x.s2; rs_val1 = x.v1; rs_val2 = x.v2;
    rs_imm = x.imm; rs_rob_idx = x.rob;
    cdb_alu_valid = x.av; cdb_alu_src = x.asrc; cdb_alu_val = x.aval;
    cdb_ld_valid = x.lv; cdb_ld_src = x.lsrc; cdb_ld_val = x.lval;
  endtask

  // One clock: check rs_full before the edge, issue port just after it.
  task automatic step(input in_t x, output logic full_seen);
    drive(x);
    #1;
    full_seen = rs_full;
    chk("rs_full", 32'(rs_full), 32'((m_count() + int'(x.ena)) >= N - 1));
    @(posedge clk);
    #1;
    model_step(x);
    chk("alu_ena", 32'(alu_ena), 32'(m_ena));
    chk("alu_opt", 32'(alu_opt), 32'(m_opt_o));
    chk("alu_val1", alu_val1, m_v1_o);
    chk("alu_val2", alu_val2, m_v2_o);
    chk("alu_imm", alu_imm, m_imm_o);
    chk("alu_rob_idx", 32'(alu_rob_idx), 32'(m_rob_o));
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    drive(idle_in());
    rst = 1'b1;
    #2;
    chk("rst_alu_ena", 32'(alu_ena), 0);
    chk("rst_alu_val1", alu_val1, 0);
    chk("rst_alu_rob", 32'(alu_rob_idx), 0);
    chk("rst_alu_opt", 32'(alu_opt), 0);
    chk("rst_full", 32'(rs_full), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic vec_t idl(logic e, logic [31:0] ev, logic [4:0] er);
    vec_t r;
    r.in = idle_in(); r.e_full = 1'b0; r.e_ena = e; r.e_v1 = ev; r.e_rob = er;
    return r;
  endfunction

  function automatic vec_t ins(logic [4:0] s1, logic [31:0] v1, logic [4:0] rob,
                               logic e, logic [31:0] ev, logic [4:0] er);
    vec_t r;
    r = idl(e, ev, er);
    r.in.ena = 1'b1; r.in.s1 = s1; r.in.v1 = v1; r.in.v2 = v1 + 7;
    r.in.imm = ~v1; r.in.rob = rob; r.in.opt = 6'(rob) + 6'd1;
    return r;
  endfunction

  initial begin
    in_t  x;
    vec_t v;
    vec_t tbl[$];
    logic f;

    do_reset();

    // Ready insert, wakeup (late and coincident), lowest-index priority.
    tbl.push_back(ins(0, 5, 3, 0, 0, 0));
    tbl.push_back(idl(1, 5, 3));
    tbl.push_back(ins(4, 32'hAA, 6, 0, 5, 3));
    tbl.push_back(idl(0, 5, 3));
    v = idl(0, 5, 3); v.in.av = 1; v.in.asrc = 4; v.in.aval = 32'h1234; tbl.push_back(v);
    tbl.push_back(idl(1, 32'h1234, 6));
    v = ins(4, 32'hBB, 7, 0, 32'h1234, 6);
    v.in.av = 1; v.in.asrc = 4; v.in.aval = 32'h1234; tbl.push_back(v);
    tbl.push_back(idl(1, 32'h1234, 7));
    tbl.push_back(ins(10, 0, 20, 0, 32'h1234, 7));
    tbl.push_back(ins(10, 1, 21, 0, 32'h1234, 7));
    tbl.push_back(ins(11, 2, 22, 0, 32'h1234, 7));
    tbl.push_back(ins(10, 3, 23, 0, 32'h1234, 7));
    tbl.push_back(ins(10, 4, 24, 0, 32'h1234, 7));
    tbl.push_back(ins(11, 5, 25, 0, 32'h1234, 7));
    v = idl(0, 32'h1234, 7); v.in.lv = 1; v.in.lsrc = 11; v.in.lval = 32'h55; tbl.push_back(v);
    tbl.push_back(idl(1, 32'h55, 22));
    tbl.push_back(idl(1, 32'h55, 25));
    v = idl(0, 32'h55, 25); v.in.av = 1; v.in.asrc = 10; v.in.aval = 32'h99; tbl.push_back(v);
    tbl.push_back(idl(1, 32'h99, 20));
    tbl.push_back(idl(1, 32'h99, 21));
    tbl.push_back(idl(1, 32'h99, 23));
    tbl.push_back(idl(1, 32'h99, 24));
    tbl.push_back(idl(0, 32'h99, 24));

    foreach (tbl[k]) begin
      step(tbl[k].in, f);
      chk($sformatf("tbl%0d_full", k), 32'(f), 32'(tbl[k].e_full));
      chk($sformatf("tbl%0d_ena", k), 32'(alu_ena), 32'(tbl[k].e_ena));
      chk($sformatf("tbl%0d_val1", k), alu_val1, tbl[k].e_v1);
      chk($sformatf("tbl%0d_rob", k), 32'(alu_rob_idx), 32'(tbl[k].e_rob));
    end

    // Fill seven entries waiting on tag 9, then release them with the load bus.
    for (int i = 0; i < 7; i++) begin
      x = idle_in(); x.ena = 1; x.s2 = 9; x.rob = 5'(i); x.v1 = 100 + i;
      step(x, f);
      chk("fill_full", 32'(f), 32'(i >= 6));
    end
    step(idle_in(), f);
    chk("full_at7", 32'(f), 1);
    x = idle_in(); x.lv = 1; x.lsrc = 9; x.lval = 32'h77;
    step(x, f);
    chk("full_bcast_ena", 32'(alu_ena), 0);
    for (int i = 0; i < 7; i++) begin
      step(idle_in(), f);
      chk("drain_full", 32'(f), 32'(i == 0));
      chk("drain_ena", 32'(alu_ena), 1);
      chk("drain_rob", 32'(alu_rob_idx), i);
      chk("drain_val2", alu_val2, 32'h77);
    end

    // Rollback with a coincident insert; later broadcasts must find nothing.
    for (int i = 0; i < 4; i++) begin
      x = idle_in(); x.ena = 1; x.s1 = 12; x.rob = 5'(8 + i);
      step(x, f);
    end
    x = idle_in(); x.rb = 1; x.ena = 1; x.rob = 17;
    step(x, f);
    chk("rb_ena", 32'(alu_ena), 0);
    x = idle_in(); x.av = 1; x.asrc = 12; x.aval = 32'hDEAD;
    step(x, f);
    for (int i = 0; i < 3; i++) begin
      step(idle_in(), f);
      chk("rb_after_ena", 32'(alu_ena), 0);
    end

    // Stall: ready entry held for three cycles, insert attempts ignored.
    x = idle_in(); x.ena = 1; x.rob = 13; x.v1 = 32'h42;
    step(x, f);
    for (int i = 0; i < 3; i++) begin
      x = idle_in(); x.rdy = 0; x.ena = 1; x.rob = 14;
      step(x, f);
      chk("stall_ena", 32'(alu_ena), 0);
    end
    step(idle_in(), f);
    chk("stall_release_ena", 32'(alu_ena), 1);
    chk("stall_release_rob", 32'(alu_rob_idx), 13);
    step(idle_in(), f);
    chk("stall_dropped_ena", 32'(alu_ena), 0);

    // Reset mid-stream with a waiting entry and nonzero issue outputs.
    x = idle_in(); x.ena = 1; x.rob = 15; x.v1 = 32'h88;
    step(x, f);
    x = idle_in(); x.ena = 1; x.s1 = 14; x.rob = 16;
    step(x, f);
    chk("pre_rst_val1", alu_val1, 32'h88);
    do_reset();
    x = idle_in(); x.av = 1; x.asrc = 14; x.aval = 32'h1;
    step(x, f);
    step(idle_in(), f);
    chk("post_rst_ena", 32'(alu_ena), 0);

    // Random traffic, including inserts while full and rollbacks.
    for (int n = 0; n < 600; n++) begin
      x = idle_in();
      x.rdy = ($urandom_range(0, 9) != 0);
      x.rb = ($urandom_range(0, 29) == 0);
      x.ena = 1'($urandom_range(0, 1));
      x.opt = 6'($urandom);
      x.s1 = ($urandom_range(0, 1) != 0) ? 5'd0 : 5'($urandom_range(1, 7));
      x.s2 = ($urandom_range(0, 2) != 0) ? 5'd0 : 5'($urandom_range(1, 7));
      x.v1 = $urandom; x.v2 = $urandom; x.imm = $urandom; x.rob = 5'($urandom);
      x.av = ($urandom_range(0, 2) == 0); x.asrc = 5'($urandom_range(0, 7));
      x.aval = $urandom;
      x.lv = ($urandom_range(0, 2) == 0); x.lsrc = 5'($urandom_range(0, 7));
      x.lval = $urandom;
      step(x, f);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rs_scheduler.md
RS_SCHEDULER -- requirements
Module: rs_scheduler

Interface
REQ-001 SHALL have parameter RS_SIZE, default 8: number of reservation-station entries (power of 2, 2..16).
REQ-002 SHALL have port clk, input, 1 bit: system clock; all state updates on posedge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port rdy, input, 1 bit: global ready; low freezes all state.
REQ-005 SHALL have port rb, input, 1 bit: rollback (ROB mispredict flush).
REQ-006 SHALL have port rs_full, output, 1 bit: combinational back-pressure to dispatcher.
REQ-007 SHALL have ports rs_ena (1), rs_opt (`INST_OPT_TP), rs_src1/rs_src2 (`ROB_IDX_TP), rs_val1/rs_val2/rs_imm (32), rs_rob_idx (`ROB_IDX_TP), all inputs: dispatch write.
REQ-008 SHALL have inputs cdb_alu_valid (1), cdb_alu_src (`ROB_IDX_TP), cdb_alu_val (32), cdb_ld_valid (1), cdb_ld_src (`ROB_IDX_TP), cdb_ld_val (32): result broadcast.
REQ-009 SHALL have outputs alu_ena (1), alu_opt (`INST_OPT_TP), alu_val1/alu_val2/alu_imm (32), alu_rob_idx (`ROB_IDX_TP), all registered: issue to ALU.

Function
REQ-010 SHALL hold per entry: valid, opt, src1, src2, val1, val2, imm, rob_idx; src == `ZERO_ROB_IDX means operand ready.
REQ-011 SHALL treat an entry as issuable iff valid and src1 == 0 and src2 == 0, evaluated on current registered state.
REQ-012 SHALL, each cycle with rdy high and rb low, select the lowest-index issuable entry, drive its fields to alu_* with alu_ena = 1 at the next edge, and clear its valid at that same edge.
REQ-013 SHALL drive alu_ena = 0 at the next edge when no entry is issuable; alu_* data then hold previous values.
REQ-014 SHALL write an incoming rs_ena packet into the lowest-index free entry (free = valid low at cycle start) at the next edge.
REQ-015 SHALL NOT issue a packet in the cycle it is written; minimum insert-to-alu_ena latency is 2 edges (write edge, issue edge).
REQ-016 SHALL wake up, per operand of every valid entry: if cdb_alu_valid and src == cdb_alu_src and src != 0, load cdb_alu_val and set src = 0; else same check with the ld bus; alu bus has priority on identical tags.
REQ-017 SHALL apply REQ-016 to the incoming packet's operands in its write cycle, so a broadcast coincident with rs_ena is not lost.
REQ-018 SHALL NOT wake up an entry being issued this cycle (already ready, no-op).
REQ-019 SHALL assert rs_full when (occupied count + rs_ena) >= RS_SIZE - 1, covering the dispatcher's one-cycle decide-to-write delay.
REQ-020 SHALL, with rs_ena high and no free entry (protocol violation), drop the packet and keep all entries unchanged.
REQ-021 SHALL, on rb high with rdy high, clear every valid bit and drive alu_ena = 0 at the next edge; rs_ena and CDB inputs that cycle are ignored.
REQ-022 SHALL, with rdy low, hold all entries and alu_* outputs unchanged and drive alu_ena = 0 at the next edge.
REQ-023 SHALL keep occupied count width log2(RS_SIZE)+1 so value RS_SIZE is representable without wrap.
REQ-024 SHALL allow insert and issue in the same cycle; an entry freed by issue is not reused until the following cycle.

Reset
REQ-025 SHALL, while rst is high, asynchronously clear all valid bits and drive alu_ena = 0, alu_opt = 0, alu_val1 = alu_val2 = alu_imm = 0, alu_rob_idx = 0.
REQ-026 SHALL, on rst asserted mid-operation, discard all entries without issuing; rs_full = 0 after reset.

Verification
REQ-027 Ready insert: rs_ena, src1 = src2 = 0, val1 = 5, val2 = 7, rob_idx = 3 -> alu_ena one cycle after the write edge with alu_val1 = 5, alu_val2 = 7, alu_rob_idx = 3.
REQ-028 Wakeup: insert src1 = 4; two cycles later cdb_alu_valid, src = 4, val = 0x1234 -> next cycle alu_ena with alu_val1 = 0x1234; coincident-with-insert broadcast -> same result.
REQ-029 Priority: entries 2 and 5 both ready same cycle -> entry 2 issues first, entry 5 the next cycle.
REQ-030 Full: RS_SIZE = 8, fill 7 entries all waiting on tag 9 -> rs_full high at 7 (and at 6 with rs_ena high); cdb_ld tag 9 -> 7 consecutive issues in index order, rs_full drops.
REQ-031 Rollback: 4 waiting entries, rb pulse with coincident rs_ena -> all valid cleared, no alu_ena, later broadcast of their tags issues nothing.
REQ-032 Stall/reset: rdy low 3 cycles with ready entry -> no alu_ena, state held, issues after rdy rises; rst mid-stream -> outputs zero immediately, rs_full 0.
